l1d_data_stage: RTL
===================

Name: l1d_data_stage

Overview:
- Second-generation L1 data-cache data stage, sitting between the dcache tag stage and writeback.
- Holds a parametrised set-associative data array: NUM_WAYS ways × NUM_SETS sets × LINE_WORDS 32-bit words.
- Performs hit reads, byte-masked stores and line fills from L2.
- Handles IO-space accesses through a request/response handshake driven by a small state machine. Misses and IO accesses are signalled to writeback as rollbacks.

Parameters:
- NUM_WAYS, 4, associativity; power of two.
- NUM_SETS, 64, sets per way; power of two.
- LINE_WORDS, 16, 32-bit words per line; equals vector lane count.
- IO_BASE_HI, 16'hffff, request_addr[31:16] value that marks IO space.

Ports:
- clk in 1: clock.
- reset in 1: asynchronous, active-high.
- dt_instruction_valid in 1: valid from tag stage.
- dt_is_load in 1: 1 = load, 0 = store.
- dt_access_type in 3: access_type_t; one of BYTE, SHORT, WORD, BLOCK, SCGATH.
- dt_lane_idx in log2(LINE_WORDS): active lane for SCGATH.
- dt_mask_value in LINE_WORDS: lane mask.
- dt_thread_idx in thread_idx_t: issuing thread.
- dt_request_addr in 32: byte address.
- dt_store_value in LINE_WORDS*32: store data.
- dt_way_hit in NUM_WAYS: one-hot hit; all zero = miss.
- dd_instruction_valid out 1: valid to writeback.
- dd_thread_idx out thread_idx_t: thread of result.
- dd_load_data out LINE_WORDS*32: endian-swapped line or scalar result.
- dd_mask_value out LINE_WORDS: registered mask.
- dd_rollback_en out 1: rollback the instruction in writeback.
- l2_fill_en in 1: fill write request.
- l2_fill_set in log2(NUM_SETS): fill set.
- l2_fill_way in log2(NUM_WAYS): fill way.
- l2_fill_data in LINE_WORDS*32: fill line.
- io_req_valid out 1: IO request valid.
- io_req_ready in 1: IO request accepted.
- io_req_store out 1: 1 = IO store.
- io_req_addr out 32: IO address.
- io_req_data out 32: IO store data.
- io_resp_valid in 1: IO read data valid.
- io_resp_data in 32: IO read data.
- wb_rollback_en in 1: rollback from writeback.
- wb_rollback_thread_idx in thread_idx_t: thread being rolled back.

Behaviour:
- Reset values: all outputs 0, IO FSM in IDLE. The data array is not reset.
- Read latency: one cycle. The array read address is {set, way} from dt_request_addr / dt_way_hit; the registered result drives dd_load_data.
- BYTE/SHORT/WORD loads: dd_load_data lane 0 holds the selected word endian-swapped; BYTE and SHORT results are zero-extended.
- Stores on hit: write in the same cycle using a byte mask.
  - BLOCK: mask = dt_mask_value per word.
  - SCGATH: one word at dt_request_addr[5:2], written only if dt_mask_value[dt_lane_idx] is set.
  - Scalar: BYTE/SHORT/WORD mask as today.
  - Store data is big-endian byte-swapped.
- Miss (valid, non-IO, dt_way_hit == 0): next cycle dd_rollback_en = 1 and dd_instruction_valid = 1; no array write.
- Fill/store collision: same set and way in the same cycle → the fill wins, the store is dropped and rolled back. A load hitting a line being filled is also rolled back.
- Rollback squash: when wb_rollback_en is set for a matching thread, dd_instruction_valid is cleared next cycle and no store or IO request is issued.
- IO FSM states: IDLE → REQ → WAIT → DONE.
  - IDLE: a valid IO access with no owner latches thread, addr and data, raises io_req_valid, rolls the instruction back, and moves to REQ.
  - REQ: hold io_req_* stable until io_req_ready. A store then goes to DONE; a load goes to WAIT.
  - WAIT: on io_resp_valid, latch the data and go to DONE.
  - DONE: the owning thread's replayed IO access completes without rollback (load returns the latched data); then go to IDLE.
  - A different thread's IO access in any non-IDLE state is rolled back.
  - Owner rollback while in DONE keeps the state.
  - Reset mid-transaction returns to IDLE and drops io_req_valid immediately.

Optional Feature:
- Macro: L1D_SIM_CONSOLE_EN.
- Defined: IO stores to IO_BASE_HI:0000 print data[7:0] via $write and complete without rollback or FSM activity.
- Undefined: all IO goes through the FSM.

Decomposition:
- Package l1d_pkg holds:
  - access_type_t;
  - io_state_t;
  - byte-swap function;
  - IO_BASE_HI default;
  - typedef line_t.
- One sub-module, l1d_data_array: NUM_WAYS*NUM_SETS lines, one read port, one byte-masked write port, registered read, fill-priority write mux.

Test Plan:
- WORD store 0x11223344 to 0x100 on way 1 hit, then load 0x100 → dd_load_data lane 0 = 0x11223344 one cycle after the load; rollback 0.
- BYTE store 0xAB to 0x103, then WORD load 0x100 → byte 3 = 0xAB, other bytes unchanged.
- Load to 0x2000 with dt_way_hit = 0 → dd_rollback_en = 1 next cycle, no array change.
- Fill and store to the same set 5 / way 2 in the same cycle → the line equals fill data and the store is rolled back.
- IO load 0xffff0010 from thread 2 with io_req_ready delayed 3 cycles and io_resp_data 0xDEAD:
  - io_req held stable for 4 cycles;
  - a thread 1 IO access is rolled back during this time;
  - thread 2's replay returns 0xDEAD with no rollback.
- Reset asserted in WAIT → io_req_valid = 0 and FSM = IDLE immediately; a subsequent IO access starts cleanly.

Source files
------------

// File: rtl/l1d_data_stage_pkg.sv
// Shared types and helpers for the L1 data-cache data stage.
package l1d_pkg;
   localparam logic [15:0] IO_BASE_HI_DEF = 16'hffff;
   localparam int LINE_WORDS_DEF = 16;
   localparam int THREADS_PER_CORE = 4;

   typedef logic [$clog2(THREADS_PER_CORE)-1:0] thread_idx_t;
   typedef logic [LINE_WORDS_DEF-1:0][31:0] line_t;

   typedef enum logic [2:0] {
      ACC_BYTE, ACC_SHORT, ACC_WORD, ACC_BLOCK, ACC_SCGATH
   } access_type_t;

   typedef enum logic [1:0] {
      IO_IDLE, IO_REQ, IO_WAIT, IO_DONE
   } io_state_t;

   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction
endpackage

// File: rtl/l1d_data_stage_if.sv
// IO-space request/response handshake between the data stage and the IO bus.
interface l1d_data_stage_if;
   logic        io_req_valid;
   logic        io_req_ready;
   logic        io_req_store;
   logic [31:0] io_req_addr;
   logic [31:0] io_req_data;
   logic        io_resp_valid;
   logic [31:0] io_resp_data;

   modport master (output io_req_valid, io_req_store, io_req_addr, io_req_data,
                   input  io_req_ready, io_resp_valid, io_resp_data);
   modport slave  (input  io_req_valid, io_req_store, io_req_addr, io_req_data,
                   output io_req_ready, io_resp_valid, io_resp_data);
endinterface

// File: rtl/l1d_data_array.sv
// Line storage banked per word: registered read, byte-masked store port, fills take priority.
module l1d_data_array #(
   parameter int NUM_WAYS   = 4,
   parameter int NUM_SETS   = 64,
   parameter int LINE_WORDS = 16
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    rd_en,
   input  logic [$clog2(NUM_WAYS*NUM_SETS)-1:0]    rd_addr,
   output logic [LINE_WORDS-1:0][31:0]             rd_data,
   input  logic                                    wr_en,
   input  logic [$clog2(NUM_WAYS*NUM_SETS)-1:0]    wr_addr,
   input  logic [LINE_WORDS-1:0][3:0]              wr_be,
   input  logic [LINE_WORDS-1:0][31:0]             wr_data,
   input  logic                                    fill_en,
   input  logic [$clog2(NUM_WAYS*NUM_SETS)-1:0]    fill_addr,
   input  logic [LINE_WORDS-1:0][31:0]             fill_data
);
   for (genvar w = 0; w < LINE_WORDS; w++) begin : g_word
      logic [31:0] bank [NUM_WAYS*NUM_SETS];
      logic [31:0] rd_q;

      always_ff @(posedge clk) begin
         if (fill_en)
            bank[fill_addr] <= fill_data[w];
         else if (wr_en)
            for (int b = 0; b < 4; b++)
               if (wr_be[w][b]) bank[wr_addr][8*b +: 8] <= wr_data[w][8*b +: 8];
      end

      // Only the output register is reset so outputs come up at zero.
      always_ff @(posedge clk or posedge reset) begin
         if (reset)      rd_q <= '0;
         else if (rd_en) rd_q <= bank[rd_addr];
      end

      assign rd_data[w] = rd_q;
   end
endmodule

// File: rtl/l1d_data_stage.sv
// L1D data stage: hit reads, byte-masked stores, L2 fills and IO-space handshake.
// Optional L1D_SIM_CONSOLE_EN: IO stores to IO_BASE_HI:0000 print a character.
module l1d_data_stage import l1d_pkg::*; #(
   parameter int          NUM_WAYS   = 4,
   parameter int          NUM_SETS   = 64,
   parameter int          LINE_WORDS = 16,
   parameter logic [15:0] IO_BASE_HI = IO_BASE_HI_DEF
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            dt_instruction_valid,
   input  logic                            dt_is_load,
   input  access_type_t                    dt_access_type,
   input  logic [$clog2(LINE_WORDS)-1:0]   dt_lane_idx,
   input  logic [LINE_WORDS-1:0]           dt_mask_value,
   input  thread_idx_t                     dt_thread_idx,
   input  logic [31:0]                     dt_request_addr,
   input  logic [LINE_WORDS*32-1:0]        dt_store_value,
   input  logic [NUM_WAYS-1:0]             dt_way_hit,
   output logic                            dd_instruction_valid,
   output thread_idx_t                     dd_thread_idx,
   output logic [LINE_WORDS*32-1:0]        dd_load_data,
   output logic [LINE_WORDS-1:0]           dd_mask_value,
   output logic                            dd_rollback_en,
   input  logic                            l2_fill_en,
   input  logic [$clog2(NUM_SETS)-1:0]     l2_fill_set,
   input  logic [$clog2(NUM_WAYS)-1:0]     l2_fill_way,
   input  logic [LINE_WORDS*32-1:0]        l2_fill_data,
   l1d_data_stage_if.master                io,
   input  logic                            wb_rollback_en,
   input  thread_idx_t                     wb_rollback_thread_idx
);
   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int SET_W  = $clog2(NUM_SETS);
   localparam int WAY_W  = $clog2(NUM_WAYS);
   localparam int OFS_W  = WORD_W + 2;

   logic [LINE_WORDS-1:0][31:0] st_lanes, wr_data, rd_line, ld_lanes;
   logic [LINE_WORDS-1:0][3:0]  wr_be;
   logic [WAY_W-1:0]  way_idx;
   logic [SET_W-1:0]  set_idx;
   logic [WORD_W-1:0] word_idx;
   logic stage_vld, is_io, miss, wr_en, load_fill_hit, console_wr, io_acc, rb_d;

   io_state_t   state_q, state_d;
   thread_idx_t owner_q;
   logic [31:0] io_addr_q, io_data_q, io_resp_q;
   logic        io_store_q, io_latch, io_resp_latch, io_rb, io_done;

   access_type_t      ld_type_q;
   logic [WORD_W-1:0] ld_word_q;
   logic [1:0]        ld_byte_q;
   logic              io_ld_q;

   assign st_lanes  = dt_store_value;
   assign stage_vld = dt_instruction_valid &&
                      !(wb_rollback_en && wb_rollback_thread_idx == dt_thread_idx);
   assign is_io     = dt_request_addr[31:16] == IO_BASE_HI;
   assign miss      = ~|dt_way_hit;
   assign set_idx   = dt_request_addr[OFS_W +: SET_W];
   assign word_idx  = dt_request_addr[2 +: WORD_W];

   always_comb begin
      way_idx = '0;
      for (int w = 0; w < NUM_WAYS; w++)
         if (dt_way_hit[w]) way_idx = way_idx | WAY_W'(w);
   end

   assign load_fill_hit = l2_fill_en && l2_fill_set == set_idx && l2_fill_way == way_idx;
   // The fill owns the single write port that cycle, so any concurrent store replays.
   assign wr_en = stage_vld && !dt_is_load && !is_io && !miss && !l2_fill_en;

   always_comb begin
      wr_be   = '0;
      wr_data = '0;
      case (dt_access_type)
         ACC_BYTE: begin
            wr_be[word_idx][dt_request_addr[1:0]] = 1'b1;
            wr_data[word_idx] = {4{st_lanes[0][7:0]}};
         end
         ACC_SHORT: begin
            wr_be[word_idx]   = dt_request_addr[1] ? 4'b1100 : 4'b0011;
            wr_data[word_idx] = {2{st_lanes[0][7:0], st_lanes[0][15:8]}};
         end
         ACC_WORD: begin
            wr_be[word_idx]   = 4'hf;
            wr_data[word_idx] = bswap32(st_lanes[0]);
         end
         ACC_BLOCK:
            for (int w = 0; w < LINE_WORDS; w++) begin
               wr_be[w]   = {4{dt_mask_value[w]}};
               wr_data[w] = bswap32(st_lanes[w]);
            end
         ACC_SCGATH:
            if (dt_mask_value[dt_lane_idx]) begin
               wr_be[word_idx]   = 4'hf;
               wr_data[word_idx] = bswap32(st_lanes[dt_lane_idx]);
            end
         default: ;
      endcase
   end

   l1d_data_array #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS), .LINE_WORDS(LINE_WORDS)) u_array (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (dt_instruction_valid),
      .rd_addr   ({set_idx, way_idx}),
      .rd_data   (rd_line),
      .wr_en     (wr_en),
      .wr_addr   ({set_idx, way_idx}),
      .wr_be     (wr_be),
      .wr_data   (wr_data),
      .fill_en   (l2_fill_en),
      .fill_addr ({l2_fill_set, l2_fill_way}),
      .fill_data (l2_fill_data)
   );

`ifdef L1D_SIM_CONSOLE_EN
   assign console_wr = stage_vld && is_io && !dt_is_load && dt_request_addr[15:0] == 16'h0;
   always_ff @(posedge clk)
      if (console_wr) $write("%c", st_lanes[0][7:0]);
`else
   assign console_wr = 1'b0;
`endif

   assign io_acc = stage_vld && is_io && !console_wr;

   always_comb begin
      state_d       = state_q;
      io_latch      = 1'b0;
      io_resp_latch = 1'b0;
      io_rb         = 1'b0;
      io_done       = 1'b0;
      case (state_q)
         IO_IDLE:
            if (io_acc) begin
               io_latch = 1'b1;
               io_rb    = 1'b1;
               state_d  = IO_REQ;
            end
         IO_REQ: begin
            io_rb = io_acc;
            if (io.io_req_ready) state_d = io_store_q ? IO_DONE : IO_WAIT;
         end
         IO_WAIT: begin
            io_rb = io_acc;
            if (io.io_resp_valid) begin
               io_resp_latch = 1'b1;
               state_d       = IO_DONE;
            end
         end
         IO_DONE:
            if (io_acc) begin
               if (dt_thread_idx == owner_q) begin
                  io_done = 1'b1;
                  state_d = IO_IDLE;
               end else begin
                  io_rb = 1'b1;
               end
            end
         default: state_d = IO_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IO_IDLE;
         owner_q    <= '0;
         io_addr_q  <= '0;
         io_data_q  <= '0;
         io_store_q <= 1'b0;
         io_resp_q  <= '0;
      end else begin
         state_q <= state_d;
         if (io_latch) begin
            owner_q    <= dt_thread_idx;
            io_addr_q  <= dt_request_addr;
            io_data_q  <= st_lanes[0];
            io_store_q <= !dt_is_load;
         end
         if (io_resp_latch) io_resp_q <= io.io_resp_data;
      end
   end

   assign io.io_req_valid = state_q == IO_REQ;
   assign io.io_req_store = io_store_q;
   assign io.io_req_addr  = io_addr_q;
   assign io.io_req_data  = io_data_q;

   assign rb_d = stage_vld && (is_io ? io_rb
                                     : (miss || (dt_is_load ? load_fill_hit : l2_fill_en)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dd_instruction_valid <= 1'b0;
         dd_rollback_en       <= 1'b0;
         dd_thread_idx        <= '0;
         dd_mask_value        <= '0;
         ld_type_q            <= ACC_BYTE;
         ld_word_q            <= '0;
         ld_byte_q            <= '0;
         io_ld_q              <= 1'b0;
      end else begin
         dd_instruction_valid <= stage_vld;
         dd_rollback_en       <= rb_d;
         if (dt_instruction_valid) begin
            dd_thread_idx <= dt_thread_idx;
            dd_mask_value <= dt_mask_value;
            ld_type_q     <= dt_access_type;
            ld_word_q     <= word_idx;
            ld_byte_q     <= dt_request_addr[1:0];
            io_ld_q       <= io_done && dt_is_load;
         end
      end
   end

   // Array words hold bytes in address order (byte 0 in bits 7:0); loads swap back.
   always_comb begin
      logic [31:0] word;
      word     = rd_line[ld_word_q];
      ld_lanes = '0;
      if (io_ld_q)
         ld_lanes[0] = io_resp_q;
      else
         case (ld_type_q)
            ACC_BYTE:  ld_lanes[0] = {24'h0, word[8*ld_byte_q +: 8]};
            ACC_SHORT: ld_lanes[0] = {16'h0, word[16*ld_byte_q[1] +: 8],
                                      word[16*ld_byte_q[1] + 8 +: 8]};
            ACC_WORD:  ld_lanes[0] = bswap32(word);
            default:
               for (int w = 0; w < LINE_WORDS; w++) ld_lanes[w] = bswap32(rd_line[w]);
         endcase
   end

   assign dd_load_data = ld_lanes;
endmodule
